// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic_lights controller and its sensor front end.
package traffic_pkg;

  // Light state encoding on the 2-bit l_a/l_b buses of traffic_lights.
  typedef enum logic [1:0] {
    LightGreen  = 2'd0,
    LightYellow = 2'd1,
    LightRed    = 2'd2
  } light_e;

  // Default conditioning parameters for the road-loop sensors.
  localparam int unsigned DEBOUNCE_DEF     = 4;
  localparam int unsigned MIN_HOLD_DEF     = 8;
  localparam int unsigned STUCK_CYCLES_DEF = 1024;

endpackage

// File: rtl/sensor_channel.sv
// One road-loop sensor channel: 2-flop synchroniser, debounce filter,
// minimum-presence stretch and stuck-high detection with output masking.
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE     = DEBOUNCE_DEF,
  parameter int unsigned MIN_HOLD     = MIN_HOLD_DEF,
  parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic t,
  output logic stuck
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam int unsigned HW = $clog2(MIN_HOLD + 1);
  localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);

  localparam logic [DW-1:0] DcntLast = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] HoldLoad = HW'(MIN_HOLD);
  localparam logic [SW-1:0] StuckMax = SW'(STUCK_CYCLES);

  logic          s1_q, s2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;

  // Debounce: deb follows s2 only after DEBOUNCE consecutive mismatching cycles.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (s2_q != deb_q) begin
      if (dcnt_q == DcntLast) begin
        deb_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  // Hold: load on a debounced rise (also reloads mid-hold), else count down to 0.
  always_comb begin
    hcnt_d = hcnt_q;
    if (deb_d && !deb_q) begin
      hcnt_d = HoldLoad;
    end else if (hcnt_q != '0) begin
      hcnt_d = hcnt_q - HW'(1);
    end
  end

  // Stuck: count debounced-high cycles, saturating; any low cycle clears.
  always_comb begin
    scnt_d = scnt_q;
    if (!deb_q) begin
      scnt_d = '0;
    end else if (scnt_q != StuckMax) begin
      scnt_d = scnt_q + SW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      deb_q  <= 1'b0;
      dcnt_q <= '0;
      hcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
      hcnt_q <= hcnt_d;
      scnt_q <= scnt_d;
    end
  end

  // Outputs decode registers only, so they cannot glitch.
  always_comb begin
    stuck = (scnt_q == StuckMax);
    t     = (deb_q | (hcnt_q != '0)) & ~stuck;
  end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the two raw loop sensors into clean t_a/t_b presence inputs.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE     = DEBOUNCE_DEF,
  parameter int unsigned MIN_HOLD     = MIN_HOLD_DEF,
  parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_b,
  output logic t_a,
  output logic t_b,
  output logic stuck_a,
  output logic stuck_b
);

  // Viale Ateneo sensor.
  sensor_channel #(
    .DEBOUNCE    (DEBOUNCE),
    .MIN_HOLD    (MIN_HOLD),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_chan_a (
    .clock(clock),
    .reset(reset),
    .raw  (raw_a),
    .t    (t_a),
    .stuck(stuck_a)
  );

  // Viale Accademia sensor.
  sensor_channel #(
    .DEBOUNCE    (DEBOUNCE),
    .MIN_HOLD    (MIN_HOLD),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_chan_b (
    .clock(clock),
    .reset(reset),
    .raw  (raw_b),
    .t    (t_b),
    .stuck(stuck_b)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner (DEBOUNCE=4, MIN_HOLD=8, STUCK_CYCLES=32).
// Tick n below is the n-th sampling edge after raw is first applied; outputs are
// sampled 1 time unit after each edge.
module tb_traffic_sensor_conditioner;

  logic clock = 1'b0;
  logic reset;
  logic raw_a, raw_b;
  logic t_a, t_b, stuck_a, stuck_b;

  int n_checks = 0;
  int n_errors = 0;

  traffic_sensor_conditioner #(
    .DEBOUNCE    (4),
    .MIN_HOLD    (8),
    .STUCK_CYCLES(32)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .t_a    (t_a),
    .t_b    (t_b),
    .stuck_a(stuck_a),
    .stuck_b(stuck_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bit i set for start <= i < start+len.
  function automatic logic [127:0] mk(input int start, input int len);
    logic [127:0] v = '0;
    for (int i = start; i < start + len; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Apply raw patterns (bit i-1 sampled at tick i) and check both channels each tick
  // against expected windows. Stuck is not checked at tick s_fall-1.
  task automatic run_vec(input string tag, input logic [127:0] pat_a, input logic [127:0] pat_b,
                         input int total,
                         input int ta_rise, input int ta_len, input int sa_rise, input int sa_fall,
                         input int tb_rise, input int tb_len, input int sb_rise, input int sb_fall);
    for (int i = 1; i <= total; i++) begin
      raw_a = pat_a[i-1];
      raw_b = pat_b[i-1];
      tick();
      check($sformatf("%s t_a@%0d", tag, i), 32'(t_a),
            32'(i >= ta_rise && i < ta_rise + ta_len));
      check($sformatf("%s t_b@%0d", tag, i), 32'(t_b),
            32'(i >= tb_rise && i < tb_rise + tb_len));
      if (!(sa_fall > 0 && i == sa_fall - 1))
        check($sformatf("%s stuck_a@%0d", tag, i), 32'(stuck_a),
              32'(i >= sa_rise && i < sa_fall));
      if (!(sb_fall > 0 && i == sb_fall - 1))
        check($sformatf("%s stuck_b@%0d", tag, i), 32'(stuck_b),
              32'(i >= sb_rise && i < sb_fall));
    end
  endtask

  task automatic settle(input int n);
    raw_a = 1'b0;
    raw_b = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // 1. Reset with both raws high: everything stays 0.
    reset = 1'b1;
    raw_a = 1'b1;
    raw_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst t_a@%0d", i), 32'(t_a), 32'd0);
      check($sformatf("rst t_b@%0d", i), 32'(t_b), 32'd0);
      check($sformatf("rst stuck_a@%0d", i), 32'(stuck_a), 32'd0);
      check($sformatf("rst stuck_b@%0d", i), 32'(stuck_b), 32'd0);
    end
    reset = 1'b0;
    // Both raws still high: rise at tick 6 after release.
    run_vec("post_rst", mk(0, 8), mk(0, 8), 8, 6, 100, 0, 0, 6, 100, 0, 0);
    settle(30);

    // 2. Short 3-cycle blip on B never reaches the output.
    run_vec("glitch_b", '0, mk(0, 3), 15, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(10);

    // 3. 5-cycle pulse on A is stretched to 8 cycles.
    run_vec("short_a", mk(0, 5), '0, 20, 6, 8, 0, 0, 0, 0, 0, 0);
    settle(10);

    // 4. 20-cycle pulse on A passes through with its own length.
    run_vec("long_a", mk(0, 20), '0, 35, 6, 20, 0, 0, 0, 0, 0, 0);
    settle(10);

    // 4b. Re-rise during the hold reloads it: continuous high for 16 cycles.
    run_vec("rerise_a", mk(0, 4) | mk(8, 4), '0, 30, 6, 16, 0, 0, 0, 0, 0, 0);
    settle(10);

    // 5. B held 45 cycles: stuck at tick 38 masks t_b, clears after deb falls.
    run_vec("stuck_b", '0, mk(0, 45), 60, 0, 0, 0, 0, 6, 32, 38, 52);
    settle(10);

    // 6. Reset mid-hold on A and mid-count on B.
    run_vec("pre_rst6", mk(17, 5), mk(0, 26), 26, 23, 8, 0, 0, 6, 100, 0, 0);
    reset = 1'b1;
    tick();
    check("rst6 t_a", 32'(t_a), 32'd0);
    check("rst6 t_b", 32'(t_b), 32'd0);
    check("rst6 stuck_b", 32'(stuck_b), 32'd0);
    reset = 1'b0;
    // B re-debounces from scratch; raw_b still high.
    run_vec("post_rst6", '0, mk(0, 8), 8, 0, 0, 0, 0, 6, 100, 0, 0);
    settle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
